// File: rtl/maxpool2d.sv
// 2D max pooling over an NCHW tensor held in a read buffer, with optional ReLU.
// Each window is read one element per cycle, then its maximum is written in a single cycle.
module maxpool2d #(
    parameter int BATCH_SIZE = 1,
    parameter int CHANNELS   = 1,
    parameter int IN_HEIGHT  = 4,
    parameter int IN_WIDTH   = 4,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int SIGNED     = 0,
    parameter int RELU_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_en,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);

    localparam int OUT_H = (IN_HEIGHT - POOL_SIZE) / STRIDE + 1;
    localparam int OUT_W = (IN_WIDTH - POOL_SIZE) / STRIDE + 1;
    localparam int N     = BATCH_SIZE * CHANNELS * OUT_H * OUT_W;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_reg, state_next;
    logic [31:0]           b_reg, b_next, c_reg, c_next;
    logic [31:0]           oh_reg, oh_next, ow_reg, ow_next;
    logic [31:0]           ph_reg, ph_next, pw_reg, pw_next;
    logic [31:0]           idx_reg, idx_next;
    logic [DATA_WIDTH-1:0] max_reg, max_next;
    logic [ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic [31:0]           rd_addr;
    logic                  first_elem;
    logic                  greater;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            b_reg        <= '0;
            c_reg        <= '0;
            oh_reg       <= '0;
            ow_reg       <= '0;
            ph_reg       <= '0;
            pw_reg       <= '0;
            idx_reg      <= '0;
            max_reg      <= '0;
            out_addr_reg <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            b_reg        <= b_next;
            c_reg        <= c_next;
            oh_reg       <= oh_next;
            ow_reg       <= ow_next;
            ph_reg       <= ph_next;
            pw_reg       <= pw_next;
            idx_reg      <= idx_next;
            max_reg      <= max_next;
            out_addr_reg <= out_addr_next;
            out_data_reg <= out_data_next;
        end
    end

    // The first element of a window seeds the max so all-negative windows work.
    always_comb begin
        first_elem = (ph_reg == 0) && (pw_reg == 0);
        if (SIGNED != 0) begin
            greater = $signed(input_data) > $signed(max_reg);
        end else begin
            greater = input_data > max_reg;
        end
        rd_addr = ((b_reg * CHANNELS + c_reg) * IN_HEIGHT + oh_reg * STRIDE + ph_reg) * IN_WIDTH
                  + ow_reg * STRIDE + pw_reg;
    end

    always_comb begin
        state_next    = state_reg;
        b_next        = b_reg;
        c_next        = c_reg;
        oh_next       = oh_reg;
        ow_next       = ow_reg;
        ph_next       = ph_reg;
        pw_next       = pw_reg;
        idx_next      = idx_reg;
        max_next      = max_reg;
        out_addr_next = out_addr_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = READ;
                    b_next     = '0;
                    c_next     = '0;
                    oh_next    = '0;
                    ow_next    = '0;
                    ph_next    = '0;
                    pw_next    = '0;
                    idx_next   = '0;
                    max_next   = '0;
                end
            end
            READ: begin
                max_next = (first_elem || greater) ? input_data : max_reg;
                if (pw_reg == POOL_SIZE - 1) begin
                    pw_next = '0;
                    if (ph_reg == POOL_SIZE - 1) begin
                        ph_next       = '0;
                        state_next    = WRITE;
                        out_addr_next = ADDR_WIDTH'(idx_reg);
                        // ReLU clamp only applies when the data is two's complement.
                        if ((SIGNED != 0) && (RELU_EN != 0) && max_next[DATA_WIDTH-1]) begin
                            out_data_next = '0;
                        end else begin
                            out_data_next = max_next;
                        end
                    end else begin
                        ph_next = ph_reg + 32'd1;
                    end
                end else begin
                    pw_next = pw_reg + 32'd1;
                end
            end
            WRITE: begin
                idx_next   = idx_reg + 32'd1;
                state_next = (idx_reg == N - 1) ? DONE : READ;
                if (ow_reg == OUT_W - 1) begin
                    ow_next = '0;
                    if (oh_reg == OUT_H - 1) begin
                        oh_next = '0;
                        if (c_reg == CHANNELS - 1) begin
                            c_next = '0;
                            b_next = b_reg + 32'd1;
                        end else begin
                            c_next = c_reg + 32'd1;
                        end
                    end else begin
                        oh_next = oh_reg + 32'd1;
                    end
                end else begin
                    ow_next = ow_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        input_en    = (state_reg == READ);
        input_addr  = (state_reg == READ) ? ADDR_WIDTH'(rd_addr) : '0;
        valid       = (state_reg == WRITE);
        output_we   = (state_reg == WRITE);
        output_en   = (state_reg == WRITE);
        done        = (state_reg == DONE);
        output_addr = out_addr_reg;
        output_data = out_data_reg;
    end

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: five parameterisations, each with its own input memory and
// a queue of expected writes that is drained as the DUT writes.
module tb_maxpool2d;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edges = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // a: defaults, s: signed, r: signed+relu, c: two channels, f: 5x5 input
    logic        a_start = 0, s_start = 0, r_start = 0, c_start = 0, f_start = 0;
    logic        a_done, a_valid, a_in_en, a_we, a_en;
    logic        s_done, s_valid, s_in_en, s_we, s_en;
    logic        r_done, r_valid, r_in_en, r_we, r_en;
    logic        c_done, c_valid, c_in_en, c_we, c_en;
    logic        f_done, f_valid, f_in_en, f_we, f_en;
    logic [15:0] a_in_addr, a_out_addr, s_in_addr, s_out_addr, r_in_addr, r_out_addr;
    logic [15:0] c_in_addr, c_out_addr, f_in_addr, f_out_addr;
    logic [7:0]  a_in_data, a_out_data, s_in_data, s_out_data, r_in_data, r_out_data;
    logic [7:0]  c_in_data, c_out_data, f_in_data, f_out_data;

    logic [7:0]  a_mem [16];
    logic [7:0]  s_mem [16];
    logic [7:0]  c_mem [32];
    logic [7:0]  f_mem [25];

    assign a_in_data = (a_in_addr < 16) ? a_mem[a_in_addr[3:0]] : 8'h00;
    assign s_in_data = (s_in_addr < 16) ? s_mem[s_in_addr[3:0]] : 8'h00;
    assign r_in_data = (r_in_addr < 16) ? s_mem[r_in_addr[3:0]] : 8'h00;
    assign c_in_data = (c_in_addr < 32) ? c_mem[c_in_addr[4:0]] : 8'h00;
    assign f_in_data = (f_in_addr < 25) ? f_mem[f_in_addr[4:0]] : 8'h00;

    maxpool2d u_a (
        .clk(clk), .rst(rst), .start(a_start), .done(a_done), .valid(a_valid),
        .input_addr(a_in_addr), .input_data(a_in_data), .input_en(a_in_en),
        .output_addr(a_out_addr), .output_data(a_out_data), .output_we(a_we), .output_en(a_en)
    );
    maxpool2d #(.SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .start(s_start), .done(s_done), .valid(s_valid),
        .input_addr(s_in_addr), .input_data(s_in_data), .input_en(s_in_en),
        .output_addr(s_out_addr), .output_data(s_out_data), .output_we(s_we), .output_en(s_en)
    );
    maxpool2d #(.SIGNED(1), .RELU_EN(1)) u_r (
        .clk(clk), .rst(rst), .start(r_start), .done(r_done), .valid(r_valid),
        .input_addr(r_in_addr), .input_data(r_in_data), .input_en(r_in_en),
        .output_addr(r_out_addr), .output_data(r_out_data), .output_we(r_we), .output_en(r_en)
    );
    maxpool2d #(.CHANNELS(2)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .done(c_done), .valid(c_valid),
        .input_addr(c_in_addr), .input_data(c_in_data), .input_en(c_in_en),
        .output_addr(c_out_addr), .output_data(c_out_data), .output_we(c_we), .output_en(c_en)
    );
    maxpool2d #(.IN_HEIGHT(5), .IN_WIDTH(5)) u_f (
        .clk(clk), .rst(rst), .start(f_start), .done(f_done), .valid(f_valid),
        .input_addr(f_in_addr), .input_data(f_in_data), .input_en(f_in_en),
        .output_addr(f_out_addr), .output_data(f_out_data), .output_we(f_we), .output_en(f_en)
    );

    exp_t qa[$], qs[$], qr[$], qc[$], qf[$];
    int   ta = 0, ts = 0, tr = 0, tc = 0, tf = 0;
    int   rd_a = 0, rd_f = 0, f_bad = 0;

    // Scoreboard monitors: cycle numbers count from the edge that sampled start (cycle 1 follows it).
    always @(negedge clk) begin
        exp_t e;
        if (a_in_en) rd_a++;
        if (a_valid) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_extra_write got addr=%0d data=%02h, want no write", a_out_addr, a_out_data);
            end else begin
                e = qa.pop_front();
                $display("a write addr=%0d data=%02h cycle=%0d", a_out_addr, a_out_data, edges - ta);
                if (a_out_addr !== e.addr || a_out_data !== e.data || (edges - ta) !== e.cyc
                    || a_we !== 1'b1 || a_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL a_write got addr=%0d data=%02h cyc=%0d we=%b en=%b, want addr=%0d data=%02h cyc=%0d we=1 en=1",
                             a_out_addr, a_out_data, edges - ta, a_we, a_en, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (s_valid) begin
            vectors++;
            if (qs.size() == 0) begin
                miscompares++;
                $display("FAIL s_extra_write got addr=%0d data=%02h, want no write", s_out_addr, s_out_data);
            end else begin
                e = qs.pop_front();
                $display("s write addr=%0d data=%02h cycle=%0d", s_out_addr, s_out_data, edges - ts);
                if (s_out_addr !== e.addr || s_out_data !== e.data || (edges - ts) !== e.cyc
                    || s_we !== 1'b1 || s_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL s_write got addr=%0d data=%02h cyc=%0d, want addr=%0d data=%02h cyc=%0d",
                             s_out_addr, s_out_data, edges - ts, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (r_valid) begin
            vectors++;
            if (qr.size() == 0) begin
                miscompares++;
                $display("FAIL r_extra_write got addr=%0d data=%02h, want no write", r_out_addr, r_out_data);
            end else begin
                e = qr.pop_front();
                $display("r write addr=%0d data=%02h cycle=%0d", r_out_addr, r_out_data, edges - tr);
                if (r_out_addr !== e.addr || r_out_data !== e.data || (edges - tr) !== e.cyc
                    || r_we !== 1'b1 || r_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL r_write got addr=%0d data=%02h cyc=%0d, want addr=%0d data=%02h cyc=%0d",
                             r_out_addr, r_out_data, edges - tr, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (c_valid) begin
            vectors++;
            if (qc.size() == 0) begin
                miscompares++;
                $display("FAIL c_extra_write got addr=%0d data=%02h, want no write", c_out_addr, c_out_data);
            end else begin
                e = qc.pop_front();
                $display("c write addr=%0d data=%02h cycle=%0d", c_out_addr, c_out_data, edges - tc);
                if (c_out_addr !== e.addr || c_out_data !== e.data || (edges - tc) !== e.cyc
                    || c_we !== 1'b1 || c_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL c_write got addr=%0d data=%02h cyc=%0d, want addr=%0d data=%02h cyc=%0d",
                             c_out_addr, c_out_data, edges - tc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (f_in_en) begin
            rd_f++;
            if (f_in_addr % 5 == 4 || f_in_addr / 5 == 4 || f_in_addr > 24) f_bad++;
        end
        if (f_valid) begin
            vectors++;
            if (qf.size() == 0) begin
                miscompares++;
                $display("FAIL f_extra_write got addr=%0d data=%02h, want no write", f_out_addr, f_out_data);
            end else begin
                e = qf.pop_front();
                $display("f write addr=%0d data=%02h cycle=%0d", f_out_addr, f_out_data, edges - tf);
                if (f_out_addr !== e.addr || f_out_data !== e.data || (edges - tf) !== e.cyc
                    || f_we !== 1'b1 || f_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL f_write got addr=%0d data=%02h cyc=%0d, want addr=%0d data=%02h cyc=%0d",
                             f_out_addr, f_out_data, edges - tf, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push_default_a();
        qa.push_back('{16'd0, 8'd5, 5});
        qa.push_back('{16'd1, 8'd7, 10});
        qa.push_back('{16'd2, 8'd13, 15});
        qa.push_back('{16'd3, 8'd15, 20});
    endtask

    // Pulse start on instance a and wait for done; returns the cycle done was first seen.
    task automatic run_a(output int done_cyc);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 ta = edges - 1;
        @(negedge clk);
        a_start = 1'b0;
        while (!a_done && (edges - ta) < 200) @(negedge clk);
        done_cyc = a_done ? (edges - ta) : -1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if ({a_done, a_valid, a_in_en, a_we, a_en, a_in_addr, a_out_addr, a_out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got done=%b valid=%b in_en=%b in_addr=%0d out_addr=%0d out_data=%02h, want all 0",
                     a_done, a_valid, a_in_en, a_in_addr, a_out_addr, a_out_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (a_done !== 1'b0 || a_in_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got done=%b in_en=%b, want 0 0", a_done, a_in_en);
        end
    endtask

    task automatic test_basic();
        int dc;
        for (int i = 0; i < 16; i++) a_mem[i] = 8'(i);
        push_default_a();
        rd_a = 0;
        run_a(dc);
        vectors++;
        if (dc !== 21) begin
            miscompares++;
            $display("FAIL basic_done_cycle got %0d, want 21", dc);
        end
        vectors++;
        if (rd_a !== 16 || qa.size() !== 0) begin
            miscompares++;
            $display("FAIL basic_reads got reads=%0d pending=%0d, want 16 0", rd_a, qa.size());
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (a_done !== 1'b1 || a_out_addr !== 16'd3 || a_out_data !== 8'd15 || a_in_en !== 1'b0
            || a_in_addr !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_hold got done=%b out_addr=%0d out_data=%02h in_en=%b in_addr=%0d, want 1 3 0f 0 0",
                     a_done, a_out_addr, a_out_data, a_in_en, a_in_addr);
        end
    endtask

    task automatic test_signed();
        logic [7:0] pat [16];
        pat = '{8'hFD, 8'hFF, 8'h80, 8'h7F, 8'hF8, 8'hFE, 8'h00, 8'h01,
                8'h10, 8'hF0, 8'h81, 8'h82, 8'h20, 8'h05, 8'h80, 8'h83};
        for (int i = 0; i < 16; i++) s_mem[i] = pat[i];
        qs.push_back('{16'd0, 8'hFF, 5});
        qs.push_back('{16'd1, 8'h7F, 10});
        qs.push_back('{16'd2, 8'h20, 15});
        qs.push_back('{16'd3, 8'h83, 20});
        qr.push_back('{16'd0, 8'h00, 5});
        qr.push_back('{16'd1, 8'h7F, 10});
        qr.push_back('{16'd2, 8'h20, 15});
        qr.push_back('{16'd3, 8'h00, 20});
        @(negedge clk);
        s_start = 1'b1;
        r_start = 1'b1;
        @(posedge clk);
        #1 ts = edges - 1;
        tr = ts;
        @(negedge clk);
        s_start = 1'b0;
        r_start = 1'b0;
        while (!(s_done && r_done) && (edges - ts) < 200) @(negedge clk);
        vectors++;
        if (!(s_done && r_done) || (edges - ts) !== 21 || qs.size() !== 0 || qr.size() !== 0) begin
            miscompares++;
            $display("FAIL signed_done got s_done=%b r_done=%b cyc=%0d pending=%0d/%0d, want 1 1 21 0/0",
                     s_done, r_done, edges - ts, qs.size(), qr.size());
        end
    endtask

    task automatic test_channels();
        for (int i = 0; i < 32; i++) c_mem[i] = 8'(i);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            v = 8'((i / 2) * 8 + (i % 2) * 2 + 5);
            qc.push_back('{16'(i), v, 5 * (i + 1)});
        end
        @(negedge clk);
        c_start = 1'b1;
        @(posedge clk);
        #1 tc = edges - 1;
        @(negedge clk);
        c_start = 1'b0;
        while (!c_done && (edges - tc) < 200) @(negedge clk);
        vectors++;
        if (!c_done || (edges - tc) !== 41 || qc.size() !== 0) begin
            miscompares++;
            $display("FAIL channels_done got done=%b cyc=%0d pending=%0d, want 1 41 0",
                     c_done, edges - tc, qc.size());
        end
    endtask

    task automatic test_floor_5x5();
        for (int i = 0; i < 25; i++) f_mem[i] = 8'(i);
        qf.push_back('{16'd0, 8'd6, 5});
        qf.push_back('{16'd1, 8'd8, 10});
        qf.push_back('{16'd2, 8'd16, 15});
        qf.push_back('{16'd3, 8'd18, 20});
        rd_f = 0;
        f_bad = 0;
        @(negedge clk);
        f_start = 1'b1;
        @(posedge clk);
        #1 tf = edges - 1;
        @(negedge clk);
        f_start = 1'b0;
        while (!f_done && (edges - tf) < 200) @(negedge clk);
        vectors++;
        if (!f_done || (edges - tf) !== 21 || qf.size() !== 0) begin
            miscompares++;
            $display("FAIL floor_done got done=%b cyc=%0d pending=%0d, want 1 21 0", f_done, edges - tf, qf.size());
        end
        vectors++;
        if (rd_f !== 16 || f_bad !== 0) begin
            miscompares++;
            $display("FAIL floor_reads got reads=%0d edge_reads=%0d, want 16 0", rd_f, f_bad);
        end
    endtask

    task automatic test_reset_midjob();
        int dc;
        qa.push_back('{16'd0, 8'd5, 5});
        qa.push_back('{16'd1, 8'd7, 10});
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 ta = edges - 1;
        @(negedge clk);
        a_start = 1'b0;
        while ((edges - ta) < 12) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({a_done, a_valid, a_in_en, a_we, a_en, a_in_addr, a_out_addr, a_out_data} !== '0) begin
            miscompares++;
            $display("FAIL midjob_reset got valid=%b in_en=%b in_addr=%0d out_addr=%0d out_data=%02h, want all 0",
                     a_valid, a_in_en, a_in_addr, a_out_addr, a_out_data);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (qa.size() !== 0 || a_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midjob_writes got pending=%0d done=%b, want 0 0", qa.size(), a_done);
        end
        rst = 1'b1;
        push_default_a();
        rd_a = 0;
        run_a(dc);
        vectors++;
        if (dc !== 21 || rd_a !== 16 || qa.size() !== 0) begin
            miscompares++;
            $display("FAIL midjob_restart got done_cyc=%0d reads=%0d pending=%0d, want 21 16 0", dc, rd_a, qa.size());
        end
    endtask

    task automatic test_back_to_back();
        push_default_a();
        rd_a = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1 ta = edges - 1;
        vectors++;
        if (a_done !== 1'b0 || a_in_en !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_from_done got done=%b in_en=%b, want 0 1", a_done, a_in_en);
        end
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        while ((edges - ta) < 4) @(negedge clk);
        a_start = 1'b1;
        repeat (3) @(negedge clk);
        a_start = 1'b0;
        while (!a_done && (edges - ta) < 200) @(negedge clk);
        vectors++;
        if (!a_done || (edges - ta) !== 21 || rd_a !== 16 || qa.size() !== 0) begin
            miscompares++;
            $display("FAIL ignored_start got done=%b cyc=%0d reads=%0d pending=%0d, want 1 21 16 0",
                     a_done, edges - ta, rd_a, qa.size());
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (a_done !== 1'b1 || rd_a !== 16) begin
            miscompares++;
            $display("FAIL done_hold got done=%b reads=%0d, want 1 16", a_done, rd_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_channels();
        test_floor_5x5();
        test_reset_midjob();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maxpool2d.md
Name: maxpool2d

Overview:
Downstream stage of conv2d. Reads the conv2d output tensor from a memory buffer (NCHW, one element per address) and applies 2D max pooling, with optional ReLU. Writes the pooled tensor to a second buffer over the same address/data/enable memory interface that conv2d uses. Driven by a start/done handshake from the layer sequencer; runs once conv2d asserts done.

Parameters:
BATCH_SIZE, 1, number of images
CHANNELS, 1, channels (equals conv2d OUT_CHANNELS)
IN_HEIGHT, 4, input rows (equals conv2d OUT_HEIGHT)
IN_WIDTH, 4, input columns (equals conv2d OUT_WIDTH)
POOL_SIZE, 2, square window edge K
STRIDE, 2, window step
DATA_WIDTH, 8, element width
ADDR_WIDTH, 16, address width
SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
RELU_EN, 0, 1 = clamp negative results to 0 (only meaningful when SIGNED=1)
Derived: OUT_H = (IN_HEIGHT-K)/STRIDE+1, OUT_W = (IN_WIDTH-K)/STRIDE+1 (floor), N = BATCH_SIZE*CHANNELS*OUT_H*OUT_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin pooling; sampled only in IDLE or DONE
done  out  1  job complete; held high until next accepted start
valid  out  1  high in each cycle that a pooled result is written
input_addr  out  ADDR_WIDTH  read address into the conv2d output buffer
input_data  in  DATA_WIDTH  read data; combinational, valid in the same cycle as input_addr/input_en
input_en  out  1  read enable
output_addr  out  ADDR_WIDTH  write address into the pool buffer
output_data  out  DATA_WIDTH  write data
output_we  out  1  write strobe
output_en  out  1  write enable (asserted together with output_we)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and running max cleared. Reset mid-job aborts the job with no further writes. Buffer contents already written are not touched.
- States:
  - IDLE: on start=1, go to READ.
  - READ: K*K cycles, one window element per cycle. Element order is pool row ph, then pool column pw. input_en=1. input_addr = ((b*CHANNELS+c)*IN_HEIGHT + oh*STRIDE+ph)*IN_WIDTH + ow*STRIDE+pw.
  - Running max: the first element of a window is loaded directly, not compared against 0. Each later element replaces the max if strictly greater, under the SIGNED rule. After the last element, go to WRITE.
  - WRITE: 1 cycle. output_en=output_we=valid=1. output_addr = linear output index 0..N-1 in order b, c, oh, ow. output_data = running max, or 0 if RELU_EN and the max is negative. Then go to READ for the next window, or to DONE after index N-1.
  - DONE: done=1. start=1 re-enters READ with all counters cleared and done dropped in the same edge.
- Start held or asserted in READ/WRITE is ignored.
- input_en=0 and input_addr=0 outside READ. output_en/we/valid are 0 outside WRITE. output_data and output_addr hold their last written value outside WRITE.
- Timing: the start edge is E0. Window n occupies reads in cycles n*(K*K+1)+1 .. n*(K*K+1)+K*K and its write in cycle (n+1)*(K*K+1). done goes high in cycle N*(K*K+1)+1.
- Rows/columns beyond the last full window (floor in OUT_H/OUT_W) are never read.
- No padding. Addresses never exceed BATCH_SIZE*CHANNELS*IN_HEIGHT*IN_WIDTH-1.

Test Plan:
1. Default params, input 0..15 row-major -> writes 5,7,13,15 to addrs 0..3. valid in cycles 5,10,15,20; done=1 from cycle 21; 16 reads total.
2. SIGNED=1, window {FD,FF,F8,FE} (-3,-1,-8,-2) -> writes FF. Same with RELU_EN=1 -> writes 00. Window {80,7F,00,01} -> 7F.
3. CHANNELS=2, channel 0 = 0..15, channel 1 = 16..31 -> addrs 0..7 = 5,7,13,15,21,23,29,31. done at cycle 41.
4. IN_HEIGHT=IN_WIDTH=5, input 0..24 -> 6,8,16,18. Row 4 and column 4 never appear on input_addr.
5. rst pulled low during the READ of window 2 -> all outputs 0 immediately, no further writes. Restart after release -> full correct result and normal timing.
6. start re-pulsed in READ -> ignored, single pass. start while in DONE -> done drops next cycle and the job repeats with identical writes.
